// File: rtl/sfft_output_arbiter.sv
// Read-port arbiter for the SFFT output buffer: host vs. peak finder, frame
// availability tracking, buffer hold line, frame counter and overrun flag.
module sfft_output_arbiter #(
    parameter int NFFT_LOG2 = 9,
    parameter int DATA_W    = 32,
    parameter int TIME_W    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_valid,
    input  logic                 host_req,
    input  logic [NFFT_LOG2-1:0] host_addr,
    input  logic                 host_done,
    output logic                 host_ack,
    output logic [DATA_W-1:0]    host_data,
    input  logic                 peak_req,
    input  logic [NFFT_LOG2-1:0] peak_addr,
    output logic                 peak_ack,
    output logic [DATA_W-1:0]    peak_data,
    output logic [NFFT_LOG2-1:0] mem_addr,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 mem_hold,
    output logic [TIME_W-1:0]    frame_count,
    output logic                 overrun
);
    // state     | meaning
    // ACC_ARB   | pick a winner, register its address
    // ACC_WAIT  | RAM samples mem_addr
    // ACC_RESP  | winner's ack high, data valid
    // FR_EMPTY  | no unread frame in the buffer
    // FR_AVAIL  | a frame is available, pipeline may still replace it
    // FR_LOCKED | host is reading; buffer held, new frames dropped
    typedef enum logic [1:0] {ACC_ARB, ACC_WAIT, ACC_RESP} acc_e;
    typedef enum logic [1:0] {FR_EMPTY, FR_AVAIL, FR_LOCKED} fr_e;

    localparam logic GR_HOST = 1'b0;
    localparam logic GR_PEAK = 1'b1;
    localparam logic [TIME_W-1:0] CNT_ONE = {{(TIME_W-1){1'b0}}, 1'b1};

    acc_e                 acc_q, acc_d;
    fr_e                  fr_q, fr_d;
    logic                 last_q, last_d;
    logic                 win_q, win_d;
    logic                 win_sel;
    logic                 host_grant;
    logic                 peak_elig;
    logic [NFFT_LOG2-1:0] addr_q, addr_d;
    logic                 hack_q, hack_d;
    logic                 pack_q, pack_d;
    logic [DATA_W-1:0]    hdata_q, hdata_d;
    logic [DATA_W-1:0]    pdata_q, pdata_d;
    logic [TIME_W-1:0]    cnt_q, cnt_d;
    logic                 ovr_q, ovr_d;

    assign peak_elig = peak_req && (fr_q != FR_EMPTY);

    always_comb begin
        acc_d      = acc_q;
        last_d     = last_q;
        win_d      = win_q;
        win_sel    = GR_HOST;
        host_grant = 1'b0;
        addr_d     = addr_q;
        hack_d     = 1'b0;
        pack_d     = 1'b0;
        hdata_d    = hdata_q;
        pdata_d    = pdata_q;
        case (acc_q)
            ACC_ARB: begin
                if (host_req || peak_elig) begin
                    // On a tie the requester that did not win last time goes first
                    if (host_req && peak_elig)
                        win_sel = (last_q == GR_PEAK) ? GR_HOST : GR_PEAK;
                    else
                        win_sel = host_req ? GR_HOST : GR_PEAK;
                    win_d      = win_sel;
                    last_d     = win_sel;
                    addr_d     = (win_sel == GR_HOST) ? host_addr : peak_addr;
                    host_grant = (win_sel == GR_HOST);
                    acc_d      = ACC_WAIT;
                end
            end
            ACC_WAIT: begin
                acc_d = ACC_RESP;
                if (win_q == GR_HOST) begin
                    hdata_d = mem_rdata;
                    hack_d  = 1'b1;
                end else begin
                    pdata_d = mem_rdata;
                    pack_d  = 1'b1;
                end
            end
            default: acc_d = ACC_ARB;
        endcase
    end

    always_comb begin
        fr_d  = fr_q;
        cnt_d = cnt_q;
        ovr_d = ovr_q;
        case (fr_q)
            FR_EMPTY: begin
                if (frame_valid) begin
                    fr_d  = FR_AVAIL;
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            FR_AVAIL: begin
                if (frame_valid)
                    cnt_d = cnt_q + CNT_ONE;
                if (host_grant) begin
                    fr_d  = FR_LOCKED;
                    ovr_d = 1'b0;
                end
            end
            FR_LOCKED: begin
                // Release takes priority; a coincident frame is then accepted
                if (host_done) begin
                    if (frame_valid) begin
                        fr_d  = FR_AVAIL;
                        cnt_d = cnt_q + CNT_ONE;
                    end else begin
                        fr_d = FR_EMPTY;
                    end
                end else if (frame_valid) begin
                    ovr_d = 1'b1;
                end
            end
            default: fr_d = FR_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= ACC_ARB;
            fr_q    <= FR_EMPTY;
            last_q  <= GR_PEAK;
            win_q   <= GR_HOST;
            addr_q  <= '0;
            hack_q  <= 1'b0;
            pack_q  <= 1'b0;
            hdata_q <= '0;
            pdata_q <= '0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            fr_q    <= fr_d;
            last_q  <= last_d;
            win_q   <= win_d;
            addr_q  <= addr_d;
            hack_q  <= hack_d;
            pack_q  <= pack_d;
            hdata_q <= hdata_d;
            pdata_q <= pdata_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
        end
    end

    assign host_ack    = hack_q;
    assign host_data   = hdata_q;
    assign peak_ack    = pack_q;
    assign peak_data   = pdata_q;
    assign mem_addr    = addr_q;
    assign mem_hold    = (fr_q == FR_LOCKED);
    assign frame_count = cnt_q;
    assign overrun     = ovr_q;
endmodule

// File: tb/tb_sfft_output_arbiter.sv
// Self-checking bench for sfft_output_arbiter; a second narrow-counter instance
// shares all inputs so frame counter wrap can be observed.
module tb_sfft_output_arbiter;
    localparam int NL = 9;
    localparam int DW = 32;
    localparam int TW = 32;

    logic clk = 1'b0;
    logic reset, frame_valid, host_req, host_done, peak_req;
    logic [NL-1:0] host_addr, peak_addr, mem_addr, mem_addr_s;
    logic host_ack, peak_ack, mem_hold, overrun;
    logic host_ack_s, peak_ack_s, mem_hold_s, overrun_s;
    logic [DW-1:0] host_data, peak_data, mem_rdata;
    logic [DW-1:0] host_data_s, peak_data_s, mem_rdata_s;
    logic [TW-1:0] frame_count;
    logic [2:0] frame_count_s;

    logic [DW-1:0] ram [0:(1<<NL)-1];
    assign mem_rdata   = ram[mem_addr];
    assign mem_rdata_s = ram[mem_addr_s];

    always #5 clk = ~clk;

    sfft_output_arbiter #(.NFFT_LOG2(NL), .DATA_W(DW), .TIME_W(TW)) dut (
        .clk(clk), .reset(reset), .frame_valid(frame_valid),
        .host_req(host_req), .host_addr(host_addr), .host_done(host_done),
        .host_ack(host_ack), .host_data(host_data),
        .peak_req(peak_req), .peak_addr(peak_addr),
        .peak_ack(peak_ack), .peak_data(peak_data),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_hold(mem_hold),
        .frame_count(frame_count), .overrun(overrun));

    sfft_output_arbiter #(.NFFT_LOG2(NL), .DATA_W(DW), .TIME_W(3)) dut_s (
        .clk(clk), .reset(reset), .frame_valid(frame_valid),
        .host_req(host_req), .host_addr(host_addr), .host_done(host_done),
        .host_ack(host_ack_s), .host_data(host_data_s),
        .peak_req(peak_req), .peak_addr(peak_addr),
        .peak_ack(peak_ack_s), .peak_data(peak_data_s),
        .mem_addr(mem_addr_s), .mem_rdata(mem_rdata_s), .mem_hold(mem_hold_s),
        .frame_count(frame_count_s), .overrun(overrun_s));

    int checks = 0;
    int errors = 0;

    // Reference model: frame state 0=empty 1=available 2=locked
    int          m_st;
    logic [31:0] m_cnt;
    bit          m_ovr;
    bit          m_last_peak;

    task automatic model_reset();
        m_st = 0; m_cnt = '0; m_ovr = 1'b0; m_last_peak = 1'b1;
    endtask

    task automatic model_grant(input bit is_peak);
        if (!is_peak && m_st == 1) begin
            m_st = 2; m_ovr = 1'b0;
        end
        m_last_peak = is_peak;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({host_ack, peak_ack, mem_hold, overrun, host_data, peak_data, mem_addr, frame_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: host_ack=%b peak_ack=%b hold=%b ovr=%b hdata=%h pdata=%h addr=%0d cnt=%0d, required all 0",
                     host_ack, peak_ack, mem_hold, overrun, host_data, peak_data, mem_addr, frame_count);
        end
        checks++;
        if ({host_ack_s, peak_ack_s, mem_hold_s, overrun_s, frame_count_s, mem_addr_s} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_narrow: cnt=%0d hold=%b, required all 0", frame_count_s, mem_hold_s);
        end
        reset = 1'b0;
        model_reset();
    endtask

    // Single read by one requester, starting with the access FSM idle.
    task automatic do_read(input bit is_peak, input logic [NL-1:0] a, input string tag);
        int n;
        logic [DW-1:0] exp;
        logic ack, other;
        logic [DW-1:0] dat;
        exp = ram[a];
        if (is_peak) begin peak_req = 1'b1; peak_addr = a; end
        else begin host_req = 1'b1; host_addr = a; end
        n = 0;
        ack = 1'b0;
        while (!ack && n < 12) begin
            @(posedge clk); #1; n++;
            ack = is_peak ? peak_ack : host_ack;
            if (n == 1) begin
                checks++;
                if (mem_addr !== a) begin
                    errors++;
                    $display("FAIL %s_mem_addr: got %0d, required %0d", tag, mem_addr, a);
                end
            end
        end
        other = is_peak ? host_ack : peak_ack;
        dat   = is_peak ? peak_data : host_data;
        checks++;
        if (n !== 2 || other !== 1'b0) begin
            errors++;
            $display("FAIL %s_latency: ack after %0d edges (other ack %b), required 2 edges, other 0", tag, n, other);
        end
        checks++;
        if (dat !== exp) begin
            errors++;
            $display("FAIL %s_data: got %h, required %h", tag, dat, exp);
        end
        peak_req = 1'b0; host_req = 1'b0;
        model_grant(is_peak);
        @(posedge clk); #1;
        ack = is_peak ? peak_ack : host_ack;
        dat = is_peak ? peak_data : host_data;
        checks++;
        if (ack !== 1'b0 || dat !== exp) begin
            errors++;
            $display("FAIL %s_ack_drop: ack=%b data=%h, required ack 0 data %h held", tag, ack, dat, exp);
        end
        checks++;
        if (mem_hold !== (m_st == 2) || frame_count !== m_cnt || overrun !== m_ovr) begin
            errors++;
            $display("FAIL %s_frame_state: hold=%b cnt=%0d ovr=%b, required hold=%b cnt=%0d ovr=%b",
                     tag, mem_hold, frame_count, overrun, m_st == 2, m_cnt, m_ovr);
        end
    endtask

    task automatic pulse(input bit fv, input bit hd, input string tag);
        frame_valid = fv; host_done = hd;
        @(posedge clk); #1;
        frame_valid = 1'b0; host_done = 1'b0;
        if (m_st == 2) begin
            if (hd) begin
                m_st = fv ? 1 : 0;
                if (fv) m_cnt++;
            end else if (fv) begin
                m_ovr = 1'b1;
            end
        end else if (fv) begin
            m_st = 1; m_cnt++;
        end
        checks++;
        if (mem_hold !== (m_st == 2) || frame_count !== m_cnt || overrun !== m_ovr || frame_count_s !== m_cnt[2:0]) begin
            errors++;
            $display("FAIL %s: hold=%b cnt=%0d ovr=%b cnt3=%0d, required hold=%b cnt=%0d ovr=%b cnt3=%0d",
                     tag, mem_hold, frame_count, overrun, frame_count_s, m_st == 2, m_cnt, m_ovr, m_cnt[2:0]);
        end
    endtask

    // Both requesters raise together; only valid with a frame present.
    task automatic do_both(input string tag);
        logic [NL-1:0] ha, pa;
        bit first_peak;
        int n;
        logic ack;
        ha = NL'($urandom_range(0, (1<<NL)-1));
        pa = NL'($urandom_range(0, (1<<NL)-1));
        first_peak = !m_last_peak;
        host_req = 1'b1; host_addr = ha; peak_req = 1'b1; peak_addr = pa;
        for (int k = 0; k < 2; k++) begin
            bit who;
            who = (k == 0) ? first_peak : !first_peak;
            n = 0; ack = 1'b0;
            while (!ack && n < 12) begin
                @(posedge clk); #1; n++;
                ack = host_ack | peak_ack;
            end
            checks++;
            if (n !== ((k == 0) ? 2 : 3) || peak_ack !== who || host_ack !== !who) begin
                errors++;
                $display("FAIL %s_order%0d: edges=%0d host_ack=%b peak_ack=%b, required edges=%0d peak_ack=%b",
                         tag, k, n, host_ack, peak_ack, (k == 0) ? 2 : 3, who);
            end
            checks++;
            if ((who ? peak_data : host_data) !== ram[who ? pa : ha]) begin
                errors++;
                $display("FAIL %s_data%0d: got %h, required %h", tag, k, who ? peak_data : host_data, ram[who ? pa : ha]);
            end
            model_grant(who);
            if (who) peak_req = 1'b0; else host_req = 1'b0;
        end
        @(posedge clk); #1;
        checks++;
        if (mem_hold !== (m_st == 2) || frame_count !== m_cnt || overrun !== m_ovr) begin
            errors++;
            $display("FAIL %s_frame_state: hold=%b cnt=%0d ovr=%b, required hold=%b cnt=%0d ovr=%b",
                     tag, mem_hold, frame_count, overrun, m_st == 2, m_cnt, m_ovr);
        end
    endtask

    task automatic test_host_read();
        ram[5] = 32'hDEADBEEF;
        do_read(1'b0, 9'd5, "host_read_empty");
    endtask

    task automatic test_peak_gating();
        int n, bad;
        peak_req = 1'b1; peak_addr = 9'd3;
        bad = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (peak_ack !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL peak_gated_empty: %0d acks seen, required 0", bad);
        end
        pulse(1'b1, 1'b0, "peak_gating_frame");
        n = 0;
        while (peak_ack !== 1'b1 && n < 12) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (n !== 2 || peak_data !== ram[3]) begin
            errors++;
            $display("FAIL peak_after_frame: ack after %0d edges data %h, required 2 edges data %h", n, peak_data, ram[3]);
        end
        peak_req = 1'b0;
        model_grant(1'b1);
        @(posedge clk); #1;
    endtask

    task automatic test_alternate();
        int bad;
        bit exp_h, exp_p, host_first;
        logic [NL-1:0] ha, pa;
        ha = 9'd17; pa = 9'd300;
        host_first = m_last_peak;
        host_req = 1'b1; host_addr = ha; peak_req = 1'b1; peak_addr = pa;
        bad = 0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            exp_h = (n % 3 == 2) && (((n / 3) % 2 == 0) == host_first);
            exp_p = (n % 3 == 2) && !exp_h;
            checks++;
            if (host_ack !== exp_h || peak_ack !== exp_p) begin
                errors++;
                $display("FAIL alternate_cycle%0d: host_ack=%b peak_ack=%b, required %b %b", n, host_ack, peak_ack, exp_h, exp_p);
            end
            if (exp_h && host_data !== ram[ha]) bad++;
            if (exp_p && peak_data !== ram[pa]) bad++;
            if (exp_h) model_grant(1'b0);
            if (exp_p) model_grant(1'b1);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL alternate_data: %0d wrong words, required 0", bad);
        end
        host_req = 1'b0; peak_req = 1'b0;
    endtask

    task automatic test_lock_overrun();
        if (m_st == 2) pulse(1'b0, 1'b1, "lock_release_prev");
        pulse(1'b1, 1'b0, "lock_new_frame");
        do_read(1'b0, 9'd42, "lock_host_read");
        pulse(1'b1, 1'b0, "overrun_1");
        pulse(1'b1, 1'b0, "overrun_2");
        pulse(1'b0, 1'b1, "lock_done");
        checks++;
        if (overrun !== 1'b1 || mem_hold !== 1'b0) begin
            errors++;
            $display("FAIL overrun_sticky: ovr=%b hold=%b, required ovr=1 hold=0", overrun, mem_hold);
        end
        pulse(1'b0, 1'b1, "done_ignored_empty");
    endtask

    task automatic test_done_and_frame();
        pulse(1'b1, 1'b0, "simul_frame");
        do_read(1'b0, 9'd99, "simul_host_read");
        pulse(1'b1, 1'b1, "simul_done_and_frame");
        pulse(1'b0, 1'b1, "simul_done_ignored_avail");
    endtask

    task automatic test_wrap();
        if (m_st == 2) pulse(1'b0, 1'b1, "wrap_release");
        for (int i = 0; i < 10; i++) pulse(1'b1, 1'b0, "wrap_frame");
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 4))
                0: pulse(1'b1, 1'b0, "rand_frame");
                1: pulse(1'b0, 1'b1, "rand_done");
                2: pulse($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, "rand_pulse");
                3: do_read(1'b0, NL'($urandom_range(0, (1<<NL)-1)), "rand_host");
                default: begin
                    if (m_st == 0) pulse(1'b1, 1'b0, "rand_fill");
                    else if ($urandom_range(0, 1) == 1) do_both("rand_both");
                    else do_read(1'b1, NL'($urandom_range(0, (1<<NL)-1)), "rand_peak");
                end
            endcase
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        host_req = 1'b1; host_addr = 9'd77;
        @(posedge clk); #1;
        checks++;
        if (mem_addr !== 9'd77) begin
            errors++;
            $display("FAIL reset_mid_wait_addr: got %0d, required 77", mem_addr);
        end
        reset = 1'b1; host_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({host_ack, peak_ack, mem_hold, overrun, host_data, peak_data, mem_addr, frame_count} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: host_ack=%b hold=%b ovr=%b hdata=%h addr=%0d cnt=%0d, required all 0",
                     host_ack, mem_hold, overrun, host_data, mem_addr, frame_count);
        end
        reset = 1'b0;
        model_reset();
        bad = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (host_ack !== 1'b0 || peak_ack !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid_no_ack: %0d acks seen, required 0", bad);
        end
        do_read(1'b0, 9'd6, "after_reset_host");
    endtask

    initial begin
        reset = 1'b1; frame_valid = 1'b0; host_req = 1'b0; host_done = 1'b0;
        peak_req = 1'b0; host_addr = '0; peak_addr = '0;
        for (int i = 0; i < (1<<NL); i++) ram[i] = $urandom;
        model_reset();
        test_reset();
        test_host_read();
        test_peak_gating();
        test_alternate();
        test_lock_overrun();
        test_done_and_frame();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
